// File: rtl/fe_branch_predictor_pkg.sv
// Shared widths, types and helpers for the fetch-side gshare branch predictor.
package fe_branch_predictor_pkg;

    localparam int unsigned DBITS          = 32;
    localparam int unsigned BHR_BITS       = 8;
    localparam int unsigned PT_INDEX_BITS  = 8;
    localparam int unsigned BTB_INDEX_BITS = 4;
    localparam int unsigned TAG_BITS       = DBITS - BTB_INDEX_BITS - 2;
    localparam int unsigned PT_ENTRIES     = 1 << PT_INDEX_BITS;
    localparam int unsigned BTB_ENTRIES    = 1 << BTB_INDEX_BITS;
    localparam int unsigned STAT_BITS      = 32;

    // Weakly not-taken
    localparam logic [1:0] PT_RESET_VAL = 2'b01;

    typedef logic [DBITS-1:0]          addr_t;
    typedef logic [BHR_BITS-1:0]       bhr_t;
    typedef logic [PT_INDEX_BITS-1:0]  pt_idx_t;
    typedef logic [BTB_INDEX_BITS-1:0] btb_idx_t;
    typedef logic [TAG_BITS-1:0]       tag_t;
    typedef logic [STAT_BITS-1:0]      stat_t;

    typedef struct packed {
        logic  is_jump;
        tag_t  tag;
        addr_t target;
    } btb_data_t;

    function automatic tag_t pc_tag(input addr_t pc);
        return pc[DBITS-1:BTB_INDEX_BITS+2];
    endfunction

    function automatic stat_t sat_inc(input stat_t v);
        return (v == '1) ? v : v + stat_t'(1);
    endfunction

endpackage

// File: rtl/fe_branch_predictor_if.sv
// Lookup, resolution-update and statistics signals between FE/AGEX and the predictor.
interface fe_branch_predictor_if;
    import fe_branch_predictor_pkg::*;

    addr_t    lookup_pc;
    logic     pred_btb_hit;
    logic     pred_taken;
    addr_t    pred_target;
    pt_idx_t  pred_pt_idx;
    btb_idx_t pred_btb_idx;

    logic     upd_valid;
    logic     upd_is_cond;
    addr_t    upd_pc;
    logic     upd_taken;
    addr_t    upd_target;
    pt_idx_t  upd_pt_idx;
    btb_idx_t upd_btb_idx;
    logic     upd_mispredict;

    bhr_t     bhr_out;
    stat_t    br_count;
    stat_t    mispred_count;

    modport master (
        output lookup_pc, upd_valid, upd_is_cond, upd_pc, upd_taken, upd_target,
               upd_pt_idx, upd_btb_idx, upd_mispredict,
        input  pred_btb_hit, pred_taken, pred_target, pred_pt_idx, pred_btb_idx,
               bhr_out, br_count, mispred_count
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_is_cond, upd_pc, upd_taken, upd_target,
               upd_pt_idx, upd_btb_idx, upd_mispredict,
        output pred_btb_hit, pred_taken, pred_target, pred_pt_idx, pred_btb_idx,
               bhr_out, br_count, mispred_count
    );

endinterface

// File: rtl/sat_counter2.sv
// 2-bit up/down saturating counter with asynchronous active-high reset.
module sat_counter2 #(
    parameter logic [1:0] ResetVal = 2'b01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up,
    output logic [1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= ResetVal;
        end else if (en) begin
            if (up && count != 2'b11) begin
                count <= count + 2'b01;
            end else if (!up && count != 2'b00) begin
                count <= count - 2'b01;
            end
        end
    end

endmodule

// File: rtl/fe_branch_predictor.sv
// Gshare predictor: BHR, 2-bit PT and direct-mapped BTB, trained at AGEX resolution.
module fe_branch_predictor
    import fe_branch_predictor_pkg::*;
(
    input logic                  clk,
    input logic                  reset,
    fe_branch_predictor_if.slave bp
);

    bhr_t                   bhr_q, bhr_d;
    logic [BTB_ENTRIES-1:0] btb_valid_q;
    btb_data_t              btb_data_q [BTB_ENTRIES];
    logic [1:0]             pt_cnt [PT_ENTRIES];
    logic [PT_ENTRIES-1:0]  pt_en;
    stat_t                  br_count_q, br_count_d;
    stat_t                  mispred_q, mispred_d;
    logic                   upd_cond, upd_btb_wr;

    pt_idx_t                lk_pt_idx;
    btb_idx_t               lk_btb_idx;
    btb_data_t              lk_entry;
    logic                   lk_hit, lk_taken;

    // Low PC bits select the BTB set and never form part of the tag.
    logic unused_upd_pc_lo;
    assign unused_upd_pc_lo = ^bp.upd_pc[BTB_INDEX_BITS+1:0];

    always_comb begin
        lk_pt_idx  = bp.lookup_pc[PT_INDEX_BITS+1:2] ^ bhr_q;
        lk_btb_idx = bp.lookup_pc[BTB_INDEX_BITS+1:2];
        lk_entry   = btb_data_q[lk_btb_idx];
        lk_hit     = btb_valid_q[lk_btb_idx] && (lk_entry.tag == pc_tag(bp.lookup_pc));
        lk_taken   = lk_hit && (lk_entry.is_jump || pt_cnt[lk_pt_idx][1]);
    end

    assign bp.pred_btb_hit  = lk_hit;
    assign bp.pred_taken    = lk_taken;
    assign bp.pred_target   = lk_taken ? lk_entry.target : bp.lookup_pc + addr_t'(4);
    assign bp.pred_pt_idx   = lk_pt_idx;
    assign bp.pred_btb_idx  = lk_btb_idx;
    assign bp.bhr_out       = bhr_q;
    assign bp.br_count      = br_count_q;
    assign bp.mispred_count = mispred_q;

    always_comb begin
        upd_cond   = bp.upd_valid && bp.upd_is_cond;
        upd_btb_wr = bp.upd_valid && bp.upd_taken;
        pt_en      = '0;
        if (upd_cond) begin
            pt_en[bp.upd_pt_idx] = 1'b1;
        end
        bhr_d      = upd_cond ? {bhr_q[BHR_BITS-2:0], bp.upd_taken} : bhr_q;
        br_count_d = bp.upd_valid ? sat_inc(br_count_q) : br_count_q;
        mispred_d  = (bp.upd_valid && bp.upd_mispredict) ? sat_inc(mispred_q) : mispred_q;
    end

    for (genvar i = 0; i < PT_ENTRIES; i++) begin : g_pt
        sat_counter2 #(
            .ResetVal (PT_RESET_VAL)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .en    (pt_en[i]),
            .up    (bp.upd_taken),
            .count (pt_cnt[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bhr_q       <= '0;
            btb_valid_q <= '0;
            br_count_q  <= '0;
            mispred_q   <= '0;
        end else begin
            bhr_q      <= bhr_d;
            br_count_q <= br_count_d;
            mispred_q  <= mispred_d;
            if (upd_btb_wr) begin
                btb_valid_q[bp.upd_btb_idx] <= 1'b1;
            end
        end
    end

    // Tag/target need no reset: the valid bit gates them.
    always_ff @(posedge clk) begin
        if (upd_btb_wr && !reset) begin
            btb_data_q[bp.upd_btb_idx] <= '{is_jump: ~bp.upd_is_cond,
                                           tag:     pc_tag(bp.upd_pc),
                                           target:  bp.upd_target};
        end
    end

endmodule

// File: tb/tb_fe_branch_predictor.sv
// Directed-vector bench for fe_branch_predictor.
module tb_fe_branch_predictor;
    import fe_branch_predictor_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    fe_branch_predictor_if bp_if ();

    fe_branch_predictor dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic look(input logic [31:0] pc);
        bp_if.lookup_pc = pc;
        #1;
    endtask

    task automatic upd(input logic cond, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic [7:0] pti, input logic [3:0] bti,
                       input logic mis);
        bp_if.upd_valid      = 1'b1;
        bp_if.upd_is_cond    = cond;
        bp_if.upd_pc         = pc;
        bp_if.upd_taken      = tk;
        bp_if.upd_target     = tgt;
        bp_if.upd_pt_idx     = pti;
        bp_if.upd_btb_idx    = bti;
        bp_if.upd_mispredict = mis;
        @(posedge clk);
        #1;
        bp_if.upd_valid      = 1'b0;
        bp_if.upd_mispredict = 1'b0;
    endtask

    initial begin
        bp_if.lookup_pc      = 32'h100;
        bp_if.upd_valid      = 1'b0;
        bp_if.upd_is_cond    = 1'b0;
        bp_if.upd_pc         = '0;
        bp_if.upd_taken      = 1'b0;
        bp_if.upd_target     = '0;
        bp_if.upd_pt_idx     = '0;
        bp_if.upd_btb_idx    = '0;
        bp_if.upd_mispredict = 1'b0;
        #22;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        look(32'h100);
        check_eq("rst_hit", 32'(bp_if.pred_btb_hit), 32'd0);
        check_eq("rst_taken", 32'(bp_if.pred_taken), 32'd0);
        check_eq("rst_target", bp_if.pred_target, 32'h104);
        check_eq("rst_bhr", 32'(bp_if.bhr_out), 32'd0);
        check_eq("rst_br_cnt", bp_if.br_count, 32'd0);
        check_eq("rst_mis_cnt", bp_if.mispred_count, 32'd0);
        check_eq("rst_pt40", 32'(dut.pt_cnt[8'h40]), 32'd1);

        // Taken conditional; same-cycle lookup must see the old state
        bp_if.upd_valid   = 1'b1;
        bp_if.upd_is_cond = 1'b1;
        bp_if.upd_pc      = 32'h100;
        bp_if.upd_taken   = 1'b1;
        bp_if.upd_target  = 32'h80;
        bp_if.upd_pt_idx  = 8'h40;
        bp_if.upd_btb_idx = 4'h0;
        bp_if.upd_mispredict = 1'b1;
        #1;
        check_eq("nobypass_hit", 32'(bp_if.pred_btb_hit), 32'd0);
        check_eq("nobypass_ptidx", 32'(bp_if.pred_pt_idx), 32'h40);
        @(posedge clk);
        #1;
        bp_if.upd_valid = 1'b0;
        bp_if.upd_mispredict = 1'b0;
        #1;
        check_eq("t1_pt40", 32'(dut.pt_cnt[8'h40]), 32'd2);
        check_eq("t1_bhr", 32'(bp_if.bhr_out), 32'h01);
        check_eq("t1_br_cnt", bp_if.br_count, 32'd1);
        check_eq("t1_mis_cnt", bp_if.mispred_count, 32'd1);
        check_eq("t1_ptidx", 32'(bp_if.pred_pt_idx), 32'h41);
        check_eq("t1_btbidx", 32'(bp_if.pred_btb_idx), 32'h0);
        check_eq("t1_hit", 32'(bp_if.pred_btb_hit), 32'd1);
        check_eq("t1_taken", 32'(bp_if.pred_taken), 32'd0);
        check_eq("t1_target", bp_if.pred_target, 32'h104);

        // Ignored when upd_valid is low
        bp_if.upd_is_cond = 1'b1;
        bp_if.upd_taken   = 1'b1;
        bp_if.upd_pt_idx  = 8'h41;
        @(posedge clk);
        #1;
        check_eq("idle_bhr", 32'(bp_if.bhr_out), 32'h01);
        check_eq("idle_pt41", 32'(dut.pt_cnt[8'h41]), 32'd1);

        // Saturation up then down on PT[0x10]
        upd(1'b1, 32'h100, 1'b1, 32'h80, 8'h10, 4'h0, 1'b0);
        check_eq("sat_up1", 32'(dut.pt_cnt[8'h10]), 32'd2);
        upd(1'b1, 32'h100, 1'b1, 32'h80, 8'h10, 4'h0, 1'b0);
        upd(1'b1, 32'h100, 1'b1, 32'h80, 8'h10, 4'h0, 1'b0);
        check_eq("sat_up3", 32'(dut.pt_cnt[8'h10]), 32'd3);
        check_eq("sat_up_bhr", 32'(bp_if.bhr_out), 32'h0F);
        for (int i = 0; i < 4; i++) begin
            upd(1'b1, 32'h100, 1'b0, 32'h0, 8'h10, 4'h0, 1'b0);
        end
        check_eq("sat_dn0", 32'(dut.pt_cnt[8'h10]), 32'd0);
        check_eq("sat_dn_bhr", 32'(bp_if.bhr_out), 32'hF0);
        check_eq("sat_br_cnt", bp_if.br_count, 32'd8);
        check_eq("sat_mis_cnt", bp_if.mispred_count, 32'd1);
        look(32'h100);
        check_eq("nt_keeps_btb", 32'(bp_if.pred_btb_hit), 32'd1);

        // JAL: BTB only, always taken
        upd(1'b0, 32'h200, 1'b1, 32'h400, 8'h55, 4'h0, 1'b0);
        check_eq("jal_bhr", 32'(bp_if.bhr_out), 32'hF0);
        check_eq("jal_pt55", 32'(dut.pt_cnt[8'h55]), 32'd1);
        look(32'h200);
        check_eq("jal_hit", 32'(bp_if.pred_btb_hit), 32'd1);
        check_eq("jal_taken", 32'(bp_if.pred_taken), 32'd1);
        check_eq("jal_target", bp_if.pred_target, 32'h400);
        look(32'h100);
        check_eq("jal_evicts", 32'(bp_if.pred_btb_hit), 32'd0);

        // Alias between 0x100 and 0x140
        upd(1'b1, 32'h100, 1'b1, 32'h80, 8'h20, 4'h0, 1'b0);
        look(32'h140);
        check_eq("alias_miss", 32'(bp_if.pred_btb_hit), 32'd0);
        upd(1'b1, 32'h140, 1'b1, 32'h300, 8'h30, 4'h0, 1'b0);
        look(32'h100);
        check_eq("alias_old_miss", 32'(bp_if.pred_btb_hit), 32'd0);
        look(32'h140);
        check_eq("alias_new_hit", 32'(bp_if.pred_btb_hit), 32'd1);
        check_eq("alias_ptidx", 32'(bp_if.pred_pt_idx), 32'h93);
        check_eq("alias_target", bp_if.pred_target, 32'h144);
        check_eq("alias_br_cnt", bp_if.br_count, 32'd11);

        // Mispredict counter saturation
        force dut.mispred_d = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.mispred_d;
        #1;
        check_eq("preload_mis", bp_if.mispred_count, 32'hFFFF_FFFF);
        upd(1'b1, 32'h100, 1'b0, 32'h0, 8'h77, 4'h0, 1'b1);
        check_eq("sat_mis_cnt_hold", bp_if.mispred_count, 32'hFFFF_FFFF);
        check_eq("sat_mis_br_cnt", bp_if.br_count, 32'd12);
        check_eq("sat_mis_bhr", 32'(bp_if.bhr_out), 32'h86);

        // Reset while an update is presented
        bp_if.upd_valid   = 1'b1;
        bp_if.upd_is_cond = 1'b1;
        bp_if.upd_pc      = 32'h200;
        bp_if.upd_taken   = 1'b1;
        bp_if.upd_target  = 32'h500;
        bp_if.upd_pt_idx  = 8'h10;
        bp_if.upd_btb_idx = 4'h0;
        bp_if.upd_mispredict = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bp_if.upd_valid = 1'b0;
        bp_if.upd_mispredict = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_bhr", 32'(bp_if.bhr_out), 32'd0);
        check_eq("mid_rst_br_cnt", bp_if.br_count, 32'd0);
        check_eq("mid_rst_mis_cnt", bp_if.mispred_count, 32'd0);
        check_eq("mid_rst_pt10", 32'(dut.pt_cnt[8'h10]), 32'd1);
        look(32'h140);
        check_eq("mid_rst_hit140", 32'(bp_if.pred_btb_hit), 32'd0);
        look(32'h200);
        check_eq("mid_rst_hit200", 32'(bp_if.pred_btb_hit), 32'd0);
        check_eq("mid_rst_taken", 32'(bp_if.pred_taken), 32'd0);
        check_eq("mid_rst_target", bp_if.pred_target, 32'h204);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fe_branch_predictor.md
# fe_branch_predictor

Fetch-side gshare branch predictor holding the branch history register (BHR), pattern table (PT) of 2-bit saturating counters, and direct-mapped branch target buffer (BTB). It answers same-cycle lookups for the fetch PC. It is the write end of the AGEX branch-resolution interface: it applies table updates when AGEX resolves a branch or jump. The PT/BTB indices used at lookup travel down the pipeline and return with the resolution, so the entry that made the guess is the entry that gets trained.

## Interface
- DBITS, 32, PC/data width
- BHR_BITS, 8, history length; equals PT_INDEX_BITS
- PT_INDEX_BITS, 8, PT entries = 2^PT_INDEX_BITS
- BTB_INDEX_BITS, 4, BTB entries = 2^BTB_INDEX_BITS
- Derived: TAG_BITS = DBITS − BTB_INDEX_BITS − 2
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- lookup_pc  in  DBITS  fetch PC, word aligned
- pred_btb_hit  out  1  valid BTB entry with matching tag
- pred_taken  out  1  predicted taken
- pred_target  out  DBITS  predicted next PC
- pred_pt_idx  out  PT_INDEX_BITS  PT index used; carried to AGEX
- pred_btb_idx  out  BTB_INDEX_BITS  BTB index used; carried to AGEX
- upd_valid  in  1  AGEX resolved a branch/jump this cycle
- upd_is_cond  in  1  1 = conditional branch, 0 = JAL/JALR
- upd_pc  in  DBITS  PC of resolved instruction
- upd_taken  in  1  actual direction
- upd_target  in  DBITS  actual target
- upd_pt_idx  in  PT_INDEX_BITS  index returned from pipeline
- upd_btb_idx  in  BTB_INDEX_BITS  index returned from pipeline
- upd_mispredict  in  1  AGEX br_cond (redirect taken)
- bhr_out  out  BHR_BITS  current BHR
- br_count  out  32  resolved branches/jumps, saturating
- mispred_count  out  32  mispredicts, saturating

## Operation
- Lookup (combinational):
  - pred_pt_idx = lookup_pc[PT_INDEX_BITS+1:2] ^ BHR.
  - pred_btb_idx = lookup_pc[BTB_INDEX_BITS+1:2].
  - Tag = lookup_pc[DBITS−1:BTB_INDEX_BITS+2].
- BTB entry = {valid, is_jump, tag, target}.
  - pred_btb_hit = valid & tag match.
  - pred_taken = hit & (is_jump | PT[pred_pt_idx][1]).
  - pred_target = pred_taken ? BTB target : lookup_pc + 4 (mod 2^DBITS).
- Update on the posedge where upd_valid = 1:
  - Conditional branch:
    - PT[upd_pt_idx] increments (saturate at 3) if taken, decrements (saturate at 0) if not.
    - BHR <= {BHR[BHR_BITS−2:0], upd_taken}.
  - Jump: PT and BHR unchanged.
  - Taken (any kind): BTB[upd_btb_idx] <= {1, ~upd_is_cond, upd_pc tag, upd_target}; this overwrites any alias.
  - Not-taken conditional: no BTB write; an existing entry is kept.
- Counters:
  - br_count += 1 on every upd_valid.
  - mispred_count += 1 on upd_valid & upd_mispredict.
  - Both hold at 32'hFFFF_FFFF.
- upd_mispredict affects only statistics. PC redirect is FE's job.
- upd_* inputs are ignored when upd_valid = 0.

## Timing
- Lookup latency 0 cycles. An update is visible to lookups from the cycle after its posedge.
- Same-cycle lookup and update of the same entry: the lookup returns the pre-update value; no bypass.
- Reset (asynchronous, any time, including while an update is pending):
  - All PT counters = 2'b01 (weakly not-taken); all BTB valid = 0.
  - BHR = 0; br_count = mispred_count = 0.
  - Resulting outputs: pred_btb_hit = 0, pred_taken = 0, pred_target = lookup_pc + 4.
  - An update presented on the clock edge where reset is asserted is dropped.
- BHR shifts at most one bit per cycle. History is non-speculative: it is updated only at resolution.

## Structure
- Shared package (VX_define.vh style): DBITS, BHR/PT/BTB index widths, TAG_BITS, PT reset value 2'b01, BTB entry field widths.
- One natural sub-module, `sat_counter2`: the 2-bit up/down saturating counter, instantiated per PT entry or used as an update function.
- BTB valid bits and PT are flops, so they reset asynchronously. BTB tag/target may be plain arrays because valid gates them.

## Test plan
- Reset, then lookup_pc = 0x100 -> hit = 0, taken = 0, target = 0x104; bhr_out = 0; both counters = 0.
- Taken conditional update (pc = 0x100, target = 0x80, pt_idx = 0x40) -> next cycle: PT[0x40] = 2, BHR = 0x01, BTB[0] valid with target 0x80. Lookup 0x100 with BHR = 1 gives idx 0x41 (counter 1) -> hit = 1, taken = 0, target = 0x104.
- Three taken updates to one PT index -> counter saturates at 3. Four not-taken -> saturates at 0.
- JAL update (pc = 0x200, target = 0x400, is_cond = 0) -> BHR unchanged; lookup 0x200 -> hit, taken, target = 0x400, regardless of PT.
- Alias: BTB entry for 0x100 written, lookup 0x140 (same idx, different tag) -> hit = 0. Taken update from 0x140 replaces the entry, so 0x100 then misses.
- Preload mispred_count to 0xFFFF_FFFF via a force, apply a mispredict update -> count stays 0xFFFF_FFFF.
- Assert reset mid-stream with upd_valid high -> all state returns to reset values and the update is dropped.
